// File: rtl/inst_prefix_parser_if.sv
// rtl/inst_prefix_parser_if.sv - byte stream, info table lookup and decoded record bundle
interface inst_prefix_parser_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  info_idx;
  logic [22:0] info_word;
  logic        dec_valid;
  logic        dec_ready;
  logic [7:0]  dec_opcode;
  logic        dec_twobyte;
  logic [22:0] dec_info;
  logic [3:0]  dec_rex;
  logic        dec_rex_present;
  logic        dec_opsize;
  logic [1:0]  dec_rep;
  logic        dec_lock;
  logic [2:0]  dec_seg;
  logic [2:0]  dec_prefix_cnt;
  logic        dec_has_modrm;
  logic [7:0]  dec_modrm;
  logic        dec_err;

  modport slave (
    input  byte_in, byte_valid, info_word, dec_ready,
    output byte_ready, info_idx, dec_valid, dec_opcode, dec_twobyte, dec_info,
           dec_rex, dec_rex_present, dec_opsize, dec_rep, dec_lock, dec_seg,
           dec_prefix_cnt, dec_has_modrm, dec_modrm, dec_err
  );

  modport master (
    output byte_in, byte_valid, info_word, dec_ready,
    input  byte_ready, info_idx, dec_valid, dec_opcode, dec_twobyte, dec_info,
           dec_rex, dec_rex_present, dec_opsize, dec_rep, dec_lock, dec_seg,
           dec_prefix_cnt, dec_has_modrm, dec_modrm, dec_err
  );
endinterface

// File: rtl/inst_prefix_parser.sv
// rtl/inst_prefix_parser.sv - x86 legacy/REX prefix, opcode and ModRM byte parser
module inst_prefix_parser (
  input  logic                 clk,
  input  logic                 reset,
  inst_prefix_parser_if.slave  bus
);
  localparam logic [1:0] ST_PREFIX = 2'd0;
  localparam logic [1:0] ST_OPC2   = 2'd1;
  localparam logic [1:0] ST_MODRM  = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

  logic [1:0]  state;
  logic [7:0]  opcode_q, modrm_q;
  logic [22:0] info_q;
  logic [3:0]  rex_q;
  logic [2:0]  seg_q, cnt_q;
  logic [1:0]  rep_q;
  logic        twobyte_q, rexp_q, opsize_q, lock_q, hm_q, err_q;

  logic        accept, is_seg, is_legacy, is_rex, hm_c;
  logic [2:0]  seg_code;
  logic [1:0]  numop, op1, op2;

  assign bus.byte_ready = (state != ST_OUT);
  assign bus.dec_valid  = (state == ST_OUT);
  assign bus.info_idx   = bus.byte_in;
  assign accept         = bus.byte_valid && (state != ST_OUT);

  always_comb begin
    seg_code = 3'd0;
    is_seg   = 1'b1;
    case (bus.byte_in)
      8'h26:   seg_code = 3'd1;
      8'h2E:   seg_code = 3'd2;
      8'h36:   seg_code = 3'd3;
      8'h3E:   seg_code = 3'd4;
      8'h64:   seg_code = 3'd5;
      8'h65:   seg_code = 3'd6;
      default: is_seg   = 1'b0;
    endcase
  end

  assign is_legacy = is_seg || (bus.byte_in == 8'h66) || (bus.byte_in == 8'hF0) ||
                     (bus.byte_in == 8'hF2) || (bus.byte_in == 8'hF3);
  assign is_rex    = (bus.byte_in[7:4] == 4'h4);

  // An operand encoded as 00/01 lives in the ModRM byte
  assign numop = bus.info_word[22:21];
  assign op1   = bus.info_word[20:19];
  assign op2   = bus.info_word[18:17];
  assign hm_c  = ((numop >= 2'd1) && !op1[1]) || ((numop >= 2'd2) && !op2[1]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_PREFIX;
      opcode_q  <= '0;
      modrm_q   <= '0;
      info_q    <= '0;
      rex_q     <= '0;
      seg_q     <= '0;
      cnt_q     <= '0;
      rep_q     <= '0;
      twobyte_q <= 1'b0;
      rexp_q    <= 1'b0;
      opsize_q  <= 1'b0;
      lock_q    <= 1'b0;
      hm_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_PREFIX: if (accept) begin
          if (is_legacy) begin
            rex_q  <= '0;
            rexp_q <= 1'b0;
            // A fifth legacy prefix is reported as the faulting opcode
            if (cnt_q == 3'd4) begin
              err_q    <= 1'b1;
              opcode_q <= bus.byte_in;
              cnt_q    <= 3'd5;
              state    <= ST_OUT;
            end else begin
              cnt_q <= cnt_q + 3'd1;
              if (is_seg)                 seg_q    <= seg_code;
              if (bus.byte_in == 8'h66)   opsize_q <= 1'b1;
              if (bus.byte_in == 8'hF0)   lock_q   <= 1'b1;
              if (bus.byte_in == 8'hF2)   rep_q    <= 2'b10;
              if (bus.byte_in == 8'hF3)   rep_q    <= 2'b11;
            end
          end else if (is_rex) begin
            rexp_q <= 1'b1;
            rex_q  <= bus.byte_in[3:0];
          end else if (bus.byte_in == 8'h0F) begin
            state <= ST_OPC2;
          end else begin
            opcode_q <= bus.byte_in;
            info_q   <= bus.info_word;
            hm_q     <= hm_c;
            state    <= hm_c ? ST_MODRM : ST_OUT;
          end
        end
        ST_OPC2: if (accept) begin
          opcode_q  <= bus.byte_in;
          twobyte_q <= 1'b1;
          info_q    <= '0;
          hm_q      <= 1'b0;
          state     <= ST_OUT;
        end
        ST_MODRM: if (accept) begin
          modrm_q <= bus.byte_in;
          state   <= ST_OUT;
        end
        default: if (bus.dec_ready) begin
          state     <= ST_PREFIX;
          opcode_q  <= '0;
          modrm_q   <= '0;
          info_q    <= '0;
          rex_q     <= '0;
          seg_q     <= '0;
          cnt_q     <= '0;
          rep_q     <= '0;
          twobyte_q <= 1'b0;
          rexp_q    <= 1'b0;
          opsize_q  <= 1'b0;
          lock_q    <= 1'b0;
          hm_q      <= 1'b0;
          err_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dec_opcode      = opcode_q;
  assign bus.dec_twobyte     = twobyte_q;
  assign bus.dec_info        = info_q;
  assign bus.dec_rex         = rex_q;
  assign bus.dec_rex_present = rexp_q;
  assign bus.dec_opsize      = opsize_q;
  assign bus.dec_rep         = rep_q;
  assign bus.dec_lock        = lock_q;
  assign bus.dec_seg         = seg_q;
  assign bus.dec_prefix_cnt  = cnt_q;
  assign bus.dec_has_modrm   = hm_q;
  assign bus.dec_modrm       = modrm_q;
  assign bus.dec_err         = err_q;
endmodule

// File: tb/tb_inst_prefix_parser.sv
// tb/tb_inst_prefix_parser.sv - scoreboard bench for inst_prefix_parser
module tb_inst_prefix_parser;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  inst_prefix_parser_if bus();
  inst_prefix_parser dut (.clk(clk), .reset(reset), .bus(bus));

  logic [22:0] info_table [256];
  assign bus.info_word = info_table[bus.info_idx];

  typedef struct {
    logic [7:0]  opcode;
    logic        twobyte;
    logic [22:0] info;
    logic [3:0]  rex;
    logic        rexp;
    logic        opsize;
    logic [1:0]  rep;
    logic        lock;
    logic [2:0]  seg;
    logic [2:0]  cnt;
    logic        hm;
    logic [7:0]  modrm;
    logic        err;
    int          stall;
    int          acc;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] bq[$];
  logic [7:0] legacy_list [9] = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h66, 8'hF0, 8'hF2};
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic hm_of(input logic [22:0] w);
    int numop, op1, op2;
    numop = int'(w[22:21]);
    op1   = int'(w[20:19]);
    op2   = int'(w[18:17]);
    return (numop >= 1 && op1 <= 1) || (numop >= 2 && op2 <= 1);
  endfunction

  function automatic logic is_leg(input logic [7:0] b);
    return b inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h66, 8'hF0, 8'hF2, 8'hF3};
  endfunction

  // Reference: walk the byte list applying the decoding rules directly
  task automatic model(output exp_t e);
    int phase;
    e = '{default: 0};
    phase = 0;
    foreach (bq[i]) begin
      logic [7:0] b;
      b = bq[i];
      if (phase == 1) begin
        e.opcode = b; e.twobyte = 1'b1; e.info = '0;
      end else if (phase == 2) begin
        e.modrm = b;
      end else if (is_leg(b)) begin
        e.rexp = 1'b0; e.rex = '0;
        if (e.cnt == 3'd4) begin
          e.err = 1'b1; e.opcode = b; e.cnt = 3'd5;
        end else begin
          e.cnt = e.cnt + 3'd1;
          case (b)
            8'h26: e.seg = 3'd1;
            8'h2E: e.seg = 3'd2;
            8'h36: e.seg = 3'd3;
            8'h3E: e.seg = 3'd4;
            8'h64: e.seg = 3'd5;
            8'h65: e.seg = 3'd6;
            8'h66: e.opsize = 1'b1;
            8'hF0: e.lock = 1'b1;
            8'hF2: e.rep = 2'b10;
            default: e.rep = 2'b11;
          endcase
        end
      end else if (b[7:4] == 4'h4) begin
        e.rexp = 1'b1; e.rex = b[3:0];
      end else if (b == 8'h0F) begin
        phase = 1;
      end else begin
        e.opcode = b; e.info = info_table[b]; e.hm = hm_of(e.info);
        if (e.hm) phase = 2;
      end
    end
  endtask

  task automatic gen();
    int nleg;
    logic [7:0] b;
    nleg = 0;
    bq.delete();
    for (int k = 0; k < 7; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) begin
        b = legacy_list[$urandom_range(0, 8)];
        if ($urandom_range(0, 3) == 0) b = 8'hF3;
        bq.push_back(b);
        nleg++;
        if (nleg == 5) return;
      end else if (r < 7) begin
        bq.push_back(8'h40 | 8'($urandom_range(0, 15)));
      end else break;
    end
    if ($urandom_range(0, 4) == 0) begin
      bq.push_back(8'h0F);
      bq.push_back(8'($urandom));
    end else begin
      do b = 8'($urandom); while (is_leg(b) || b[7:4] == 4'h4 || b == 8'h0F);
      bq.push_back(b);
      if (hm_of(info_table[b])) bq.push_back(8'($urandom));
    end
  endtask

  task automatic send(input logic [7:0] b, output int acc);
    int t;
    t = 0;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
      bus.byte_in = 8'($urandom);
    end
    @(negedge clk);
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      vectors++; miscompares++;
      $display("FAIL byte_accept_timeout: byte_ready stuck at %0b, required 1", bus.byte_ready);
    end
    acc = cyc;
    @(posedge clk);
    #1 bus.byte_valid = 1'b0;
  endtask

  task automatic run_instr(input int stall);
    exp_t e;
    int acc;
    model(e);
    acc = 0;
    foreach (bq[i]) send(bq[i], acc);
    e.stall = stall;
    e.acc = acc;
    expq.push_back(e);
  endtask

  function automatic logic [56:0] rec_now();
    return {bus.dec_opcode, bus.dec_twobyte, bus.dec_info, bus.dec_rex, bus.dec_rex_present,
            bus.dec_opsize, bus.dec_rep, bus.dec_lock, bus.dec_seg, bus.dec_prefix_cnt,
            bus.dec_has_modrm, bus.dec_modrm, bus.dec_err};
  endfunction

  initial begin
    logic [56:0] snap;
    logic busy;
    int hold;
    exp_t e;
    busy = 1'b0;
    hold = 0;
    snap = '0;
    bus.dec_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy = 1'b0;
        hold = 0;
        bus.dec_ready = 1'b0;
      end else if (bus.dec_valid) begin
        if (!busy) begin
          if (expq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL spurious_record: got opcode %0h, required no record", bus.dec_opcode);
            hold = 0;
          end else begin
            e = expq.pop_front();
            chk("opcode", bus.dec_opcode, e.opcode);
            chk("twobyte", bus.dec_twobyte, e.twobyte);
            chk("info", bus.dec_info, e.info);
            chk("rex", bus.dec_rex, e.rex);
            chk("rex_present", bus.dec_rex_present, e.rexp);
            chk("opsize", bus.dec_opsize, e.opsize);
            chk("rep", bus.dec_rep, e.rep);
            chk("lock", bus.dec_lock, e.lock);
            chk("seg", bus.dec_seg, e.seg);
            chk("prefix_cnt", bus.dec_prefix_cnt, e.cnt);
            chk("has_modrm", bus.dec_has_modrm, e.hm);
            chk("modrm", bus.dec_modrm, e.modrm);
            chk("err", bus.dec_err, e.err);
            chk("latency", 64'(cyc), 64'(e.acc + 1));
            hold = (e.stall > 0) ? e.stall : $urandom_range(0, 2);
          end
          snap = rec_now();
          busy = 1'b1;
        end else begin
          chk("stable_while_stalled", rec_now(), snap);
        end
        chk("byte_ready_in_out", bus.byte_ready, 1'b0);
        if (hold > 0) begin
          bus.dec_ready = 1'b0;
          hold--;
        end else begin
          bus.dec_ready = 1'b1;
          busy = 1'b0;
        end
      end else begin
        bus.dec_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    int t;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    foreach (info_table[i]) info_table[i] = 23'($urandom);
    info_table[8'h01] = 23'b10010011110000000000000;
    info_table[8'h89] = 23'b10010011110000000000000;
    info_table[8'h55] = 23'b01110011000101000000000;
    info_table[8'h90] = '0;

    repeat (2) @(negedge clk);
    chk("reset_dec_valid", bus.dec_valid, 1'b0);
    chk("reset_byte_ready", bus.byte_ready, 1'b1);
    chk("reset_record", rec_now(), 57'd0);
    reset = 1'b1;

    bq = {8'h01, 8'hC8};                      run_instr(0);
    bq = {8'h66, 8'hF3, 8'h48, 8'h89, 8'hD8}; run_instr(3);
    bq = {8'h41, 8'h2E, 8'h55};               run_instr(0);
    bq = {8'h0F, 8'h05};                      run_instr(0);
    bq = {8'h26, 8'h26, 8'h66, 8'hF0, 8'hF2}; run_instr(0);

    // Partial instruction abandoned by reset: no record may follow
    begin
      int acc;
      send(8'h66, acc);
      send(8'h89, acc);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_dec_valid", bus.dec_valid, 1'b0);
    chk("midreset_byte_ready", bus.byte_ready, 1'b1);
    chk("midreset_record", rec_now(), 57'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.byte_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_reset_dec_valid", bus.dec_valid, 1'b0);
      chk("post_reset_byte_ready", bus.byte_ready, 1'b1);
    end
    bq = {8'h90}; run_instr(0);

    repeat (300) begin
      gen();
      run_instr(0);
    end

    t = 0;
    while ((expq.size() != 0 || bus.dec_valid) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inst_prefix_parser.md
INST_PREFIX_PARSER -- requirements
Module: inst_prefix_parser

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 byte_in  input  8  next instruction byte from the fetch queue.
REQ-005 byte_valid  input  1  byte_in holds a valid byte.
REQ-006 byte_ready  output  1  parser accepts byte_in this cycle; a transfer occurs when byte_valid and byte_ready are both 1.
REQ-007 info_idx  output  8  index into the opcode info table; equals byte_in combinationally.
REQ-008 info_word  input  23  table entry for info_idx, valid in the same cycle; bits are numop[22:21], op1[20:19], op2[18:17], with the remaining bits ignored.
REQ-009 dec_valid  output  1  decoded record valid.
REQ-010 dec_ready  input  1  consumer accepts the record.
REQ-011 The record SHALL contain these outputs:
  - dec_opcode[7:0]
  - dec_twobyte[0]
  - dec_info[22:0]
  - dec_rex[3:0] (W,R,X,B)
  - dec_rex_present
  - dec_opsize (66 seen)
  - dec_rep[1:0] (00 none, 10 F2, 11 F3)
  - dec_lock
  - dec_seg[2:0] (0 none, 1 ES, 2 CS, 3 SS, 4 DS, 5 FS, 6 GS)
  - dec_prefix_cnt[2:0]
  - dec_has_modrm
  - dec_modrm[7:0]
  - dec_err

Function
REQ-012 The FSM SHALL have states PREFIX, OPC2, MODRM and OUT; byte_ready SHALL be 1 in PREFIX, OPC2 and MODRM, and 0 in OUT.
REQ-013 PREFIX, accepted byte 26/2E/36/3E/64/65: set dec_seg, where the last one wins; increment prefix count; clear REX fields; stay in PREFIX.
REQ-014 PREFIX, byte 66: set opsize; count it; clear REX; stay in PREFIX.
REQ-015 PREFIX, byte F0: set lock; count it; clear REX; stay in PREFIX.
REQ-016 PREFIX, byte F2 or F3: set rep, where the last one wins; count it; clear REX; stay in PREFIX.
REQ-017 PREFIX, byte 40-4F: set rex_present and load dec_rex from the low nibble, where a later REX overwrites; REX is not counted.
REQ-018 A legacy prefix accepted after a REX SHALL clear rex_present and dec_rex to 0.
REQ-019 If a fifth legacy prefix is accepted, the parser SHALL set dec_err, load that byte as dec_opcode, and go to OUT.
REQ-020 PREFIX, byte 0F: go to OPC2.
  - In OPC2 the next accepted byte becomes dec_opcode with dec_twobyte=1.
  - dec_info SHALL be 0 and dec_has_modrm SHALL be 0.
  - The FSM then goes to OUT.
REQ-021 PREFIX, any other byte: opcode.
  - Latch dec_opcode=byte_in and dec_info=info_word in the same cycle.
  - Compute has_modrm = (numop>=1 and op1 in {00,01}) or (numop>=2 and op2 in {00,01}).
  - If has_modrm, go to MODRM; otherwise go to OUT.
REQ-022 MODRM: the next accepted byte SHALL be latched into dec_modrm, and the FSM goes to OUT.
REQ-023 PREFIX, OPC2 and MODRM SHALL hold state while byte_valid is 0.
REQ-024 OUT: dec_valid=1 and all record fields SHALL be held stable until dec_ready=1.
  - On that cycle, return to PREFIX with all prefix state, count, err, modrm and twobyte cleared.
  - No byte is accepted in the handshake cycle.
REQ-025 Latency: a non-ModRM opcode accepted at edge N SHALL give dec_valid=1 after edge N.
  - With ModRM, dec_valid=1 after the ModRM byte edge.
  - Throughput is one record per (bytes+1) cycles.
REQ-026 dec_prefix_cnt SHALL count legacy prefixes only, with values 0-4, or 5 when dec_err=1; it SHALL never wrap.
REQ-027 Outside OUT, dec_valid SHALL be 0 and the other record outputs are don't-care.

Reset
REQ-028 While reset=0, the FSM SHALL be in PREFIX.
  - dec_valid=0 and byte_ready=1.
  - All record registers are 0.
REQ-029 Reset asserted mid-instruction, in any state, SHALL discard partial prefixes, opcode and ModRM immediately; no record is emitted.

Verification
REQ-030 Bytes 01 C8 with info_word[01]=23'b10010011110000000000000:
  - Required response: one record with dec_opcode=01, dec_has_modrm=1, dec_modrm=C8, dec_rex_present=0, dec_prefix_cnt=0.
REQ-031 Bytes 66 F3 48 89 D8, with dec_ready held 0 for 3 cycles:
  - Required response: one record with opsize=1, rep=11, rex=1000, prefix_cnt=2, opcode=89, modrm=D8.
  - Fields SHALL stay stable while stalled, and byte_ready=0 during OUT.
REQ-032 Bytes 41 2E 55 with info_word[55]=23'b01110011000101000000000:
  - Required response: rex_present=0, dec_seg=2, has_modrm=0.
  - dec_valid SHALL be 1 the cycle after 55 is accepted.
REQ-033 Bytes 0F 05:
  - Required response: one record with dec_twobyte=1, dec_opcode=05, dec_info=0, has_modrm=0.
REQ-034 Bytes 26 26 66 F0 F2:
  - Required response: a record with dec_err=1, dec_opcode=F2, prefix_cnt=5.
REQ-035 Bytes 66 89, then reset low for 1 cycle, then byte_valid=0 after release:
  - Required response: no record, dec_valid=0, byte_ready=1.
  - A subsequent 90 with info_word=0 SHALL yield a record with opcode=90, opsize=0, has_modrm=0.
